// File: rtl/store_buffer.sv
// store_buffer
//   Store-side write buffer between the MEM stage and the data-memory write
//   port. Each RISC-V store (SB/SH/SW/SD) is lane-aligned: data is replicated
//   across the word and byte strobes are built. The result is queued in a
//   small FIFO that drains over a valid/ready handshake. This keeps memory
//   write stalls from reaching the pipeline.
//
// Parameters
//   XLEN   datapath width, 32 or 64
//   DEPTH  FIFO entries, power of two, >= 2
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   st_valid / st_ready   store request handshake (st_ready = buffer not full)
//   st_funct3             store width: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64)
//   st_addr, st_data      byte address and right-justified store data
//   st_err                one-cycle pulse: illegal funct3 was dropped
//   st_misalign           one-cycle pulse: misaligned store was dropped
//   mem_valid / mem_ready head-of-queue handshake toward memory
//   mem_addr, mem_wdata   word-aligned address and lane-replicated data
//   mem_wstrb             byte enables
//   count, empty          occupancy
//
// Configuration macro
//   MISALIGN_EXC_EN  when defined, misaligned SH/SW/SD stores are dropped and
//                    flagged on st_misalign. When undefined, the low address
//                    bits below the access size are ignored and st_misalign
//                    stays 0.

module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_funct3,
  input  logic [XLEN-1:0]          st_addr,
  input  logic [XLEN-1:0]          st_data,
  output logic                     st_err,
  output logic                     st_misalign,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [OFFW-1:0] off;
  logic            legal;
  logic [XLEN-1:0] laneData;
  logic [NB-1:0]   laneStrb;
  logic [XLEN-1:0] alignedAddr;

  logic            accept;
  logic            push;
  logic            pop;
  logic            full;
  logic            misalignDrop;

  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            stErr_q, stErr_d;

  logic [XLEN-1:0] addrMem_q  [DEPTH];
  logic [XLEN-1:0] wdataMem_q [DEPTH];
  logic [NB-1:0]   strbMem_q  [DEPTH];

  assign off         = st_addr[OFFW-1:0];
  assign alignedAddr = {st_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

  // Lane formation: replicate the store data across every lane of its size.
  // Strobes start at the naturally aligned offset, so the offset bits below
  // the access size are masked off before shifting.
  always_comb begin
    legal    = 1'b0;
    laneData = '0;
    laneStrb = '0;
    case (st_funct3)
      3'b000: begin
        legal    = 1'b1;
        laneData = {NB{st_data[7:0]}};
        laneStrb = NB'(1) << off;
      end
      3'b001: begin
        legal    = 1'b1;
        laneData = {(NB/2){st_data[15:0]}};
        laneStrb = NB'(2'b11) << (off & ~OFFW'(1));
      end
      3'b010: begin
        legal    = 1'b1;
        laneData = {(NB/4){st_data[31:0]}};
        laneStrb = NB'(4'hF) << (off & ~OFFW'(3));
      end
      3'b011: begin
        legal    = (XLEN == 64);
        laneData = st_data;
        laneStrb = '1;
      end
      default: begin
        legal    = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_EXC_EN
  logic misalignHit;
  logic stMisalign_q, stMisalign_d;

  // A store is misaligned when its offset is not a multiple of its size.
  always_comb begin
    misalignHit = 1'b0;
    case (st_funct3)
      3'b001:  misalignHit = off[0];
      3'b010:  misalignHit = |off[1:0];
      3'b011:  misalignHit = |off;
      default: misalignHit = 1'b0;
    endcase
  end

  assign misalignDrop = accept && legal && misalignHit;
  assign stMisalign_d = misalignDrop;
  assign st_misalign  = stMisalign_q;

  // Registered misalignment pulse for the cycle after the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stMisalign_q <= 1'b0;
    end else begin
      stMisalign_q <= stMisalign_d;
    end
  end
`else
  assign misalignDrop = 1'b0;
  assign st_misalign  = 1'b0;
`endif

  // st_ready depends only on occupancy. A full buffer refuses a new store
  // even in a cycle when the head is draining.
  assign full     = (count_q == CNTW'(DEPTH));
  assign st_ready = !full;
  assign accept   = st_valid && st_ready;
  assign push     = accept && legal && !misalignDrop;
  assign empty    = (count_q == '0);
  assign mem_valid = !empty;
  assign pop      = mem_valid && mem_ready;
  assign count    = count_q;

  // The illegal-op pulse flags any presented illegal store, whether or not
  // the buffer is full at the time.
  assign stErr_d = st_valid && !legal;
  assign st_err  = stErr_q;

  // Pointer and occupancy next state. Pointers wrap naturally because DEPTH
  // is a power of two. The extra count bit separates full from empty.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTRW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTRW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state is reset asynchronously. Reset drops all queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      stErr_q <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      stErr_q <= stErr_d;
    end
  end

  // Entry storage needs no reset. Stale contents are never visible because
  // the outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem_q[wrPtr_q]  <= alignedAddr;
      wdataMem_q[wrPtr_q] <= laneData;
      strbMem_q[wrPtr_q]  <= laneStrb;
    end
  end

  // The head entry drives the memory port. It is held until popped, so it
  // stays stable while memory stalls.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (!empty) begin
      mem_addr  = addrMem_q[rdPtr_q];
      mem_wdata = wdataMem_q[rdPtr_q];
      mem_wstrb = strbMem_q[rdPtr_q];
    end
  end

endmodule
